// File: rtl/instr_encoder_if.sv
// Field-bundle input and encoded-word output channels of the instruction encoder.
interface instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  fmt;
   logic [6:0]  op;
   logic [5:0]  rs;
   logic [5:0]  rt;
   logic [5:0]  rd;
   logic [5:0]  shamt;
   logic [6:0]  func;
   logic [15:0] offset;
   logic [25:0] target;
   logic [31:0] out_word;
   logic        out_valid;
   logic        out_ready;

   modport master (
      output in_valid, fmt, op, rs, rt, rd, shamt, func, offset, target, out_ready,
      input  in_ready, out_word, out_valid
   );

   modport slave (
      input  in_valid, fmt, op, rs, rt, rd, shamt, func, offset, target, out_ready,
      output in_ready, out_word, out_valid
   );
endinterface

// File: rtl/instr_encoder.sv
// Packs R/I/J field bundles into 32-bit instruction words, buffered in a 4-entry FIFO.
// Illegal bundles are consumed, dropped, and reported through err_pulse/err_cnt.
module instr_encoder (
   input  logic              clk,
   input  logic              rst,
   instr_encoder_if.slave    bus,
   output logic [2:0]        count,
   output logic              err_pulse,
   output logic [7:0]        err_cnt
);

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned PTR_W  = 2;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned WORD_W = 32;

   logic [WORD_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [WORD_W-1:0] word;
   logic              illegal;
   logic              accept;
   logic              push;
   logic              pop;

   // Field legality and word packing per format
   always_comb begin
      illegal = 1'b0;
      word    = '0;
      case (bus.fmt)
         2'b00: begin
            illegal = bus.op[6] | bus.rs[5] | bus.rt[5] | bus.rd[5] |
                      bus.shamt[5] | bus.func[6];
            word    = {bus.op[5:0], bus.rs[4:0], bus.rt[4:0], bus.rd[4:0],
                       bus.shamt[4:0], bus.func[5:0]};
         end
         2'b01: begin
            illegal = bus.op[6] | bus.rs[5] | bus.rt[5];
            word    = {bus.op[5:0], bus.rs[4:0], bus.rt[4:0], bus.offset};
         end
         2'b10: begin
            illegal = bus.op[6];
            word    = {bus.op[5:0], bus.target};
         end
         default: begin
            illegal = 1'b1;
            word    = '0;
         end
      endcase
   end

   assign bus.in_ready  = (count < CNT_W'(DEPTH));
   assign bus.out_valid = (count != '0);
   assign bus.out_word  = mem[rd_ptr];

   assign accept = bus.in_valid & bus.in_ready;
   assign push   = accept & ~illegal;
   assign pop    = bus.out_valid & bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         err_pulse <= 1'b0;
         err_cnt   <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= word;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         err_pulse <= accept & illegal;
         // Saturate at all-ones so a stuck source cannot wrap the counter
         if (accept && illegal && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed table and sequence bench for instr_encoder.
module tb_instr_encoder;

   typedef struct {
      logic [1:0]  fmt;
      logic [6:0]  op;
      logic [5:0]  rs;
      logic [5:0]  rt;
      logic [5:0]  rd;
      logic [5:0]  shamt;
      logic [6:0]  func;
      logic [15:0] offset;
      logic [25:0] target;
      logic        legal;
      logic [31:0] word;
   } vec_t;

   logic       clk;
   logic       rst;
   logic [2:0] count;
   logic       err_pulse;
   logic [7:0] err_cnt;

   int passed;
   int total;

   instr_encoder_if bus ();

   instr_encoder dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .count     (count),
      .err_pulse (err_pulse),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         passed++;
      end
   endtask

   task automatic clear_fields();
      bus.fmt    = 2'b00;
      bus.op     = '0;
      bus.rs     = '0;
      bus.rt     = '0;
      bus.rd     = '0;
      bus.shamt  = '0;
      bus.func   = '0;
      bus.offset = '0;
      bus.target = '0;
   endtask

   task automatic drive_vec(input vec_t v);
      bus.fmt    = v.fmt;
      bus.op     = v.op;
      bus.rs     = v.rs;
      bus.rt     = v.rt;
      bus.rd     = v.rd;
      bus.shamt  = v.shamt;
      bus.func   = v.func;
      bus.offset = v.offset;
      bus.target = v.target;
      bus.in_valid = 1'b1;
   endtask

   task automatic drive_j(input logic [25:0] tg);
      clear_fields();
      bus.fmt      = 2'b10;
      bus.op       = 7'd2;
      bus.target   = tg;
      bus.in_valid = 1'b1;
   endtask

   function automatic vec_t mk(input logic [1:0] f, input logic [6:0] o,
                               input logic [5:0] s, input logic [5:0] t,
                               input logic [5:0] d, input logic [5:0] sh,
                               input logic [6:0] fn, input logic [15:0] off,
                               input logic [25:0] tg, input logic lg,
                               input logic [31:0] w);
      vec_t v;
      v.fmt = f; v.op = o; v.rs = s; v.rt = t; v.rd = d; v.shamt = sh;
      v.func = fn; v.offset = off; v.target = tg; v.legal = lg; v.word = w;
      return v;
   endfunction

   vec_t vecs [13];

   initial begin
      int exp_err;
      passed = 0;
      total  = 0;

      vecs[0]  = mk(2'b00, 7'h00, 6'd31, 6'd7,  6'd9,  6'd0,  7'd3,    16'h0000, 26'h0,       1'b1, 32'h03E74803);
      vecs[1]  = mk(2'b01, 7'h23, 6'd1,  6'd8,  6'd0,  6'd0,  7'd0,    16'h0020, 26'h0,       1'b1, 32'h8C280020);
      vecs[2]  = mk(2'b10, 7'h02, 6'd0,  6'd0,  6'd0,  6'd0,  7'd0,    16'h0000, 26'h0ABCDEF, 1'b1, 32'h08ABCDEF);
      vecs[3]  = mk(2'b00, 7'h3F, 6'd31, 6'd31, 6'd31, 6'd31, 7'h3F,   16'h0000, 26'h0,       1'b1, 32'hFFFFFFFF);
      vecs[4]  = mk(2'b01, 7'h08, 6'd2,  6'd3,  6'd63, 6'd63, 7'h7F,   16'hFFFF, 26'h0,       1'b1, 32'h2043FFFF);
      vecs[5]  = mk(2'b10, 7'h03, 6'd63, 6'd63, 6'd63, 6'd63, 7'h7F,   16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h0FFFFFFF);
      vecs[6]  = mk(2'b11, 7'h00, 6'd0,  6'd0,  6'd0,  6'd0,  7'd0,    16'h0000, 26'h0,       1'b0, 32'h0);
      vecs[7]  = mk(2'b00, 7'h00, 6'd32, 6'd0,  6'd0,  6'd0,  7'd0,    16'h0000, 26'h0,       1'b0, 32'h0);
      vecs[8]  = mk(2'b10, 7'h40, 6'd0,  6'd0,  6'd0,  6'd0,  7'd0,    16'h0000, 26'h1,       1'b0, 32'h0);
      vecs[9]  = mk(2'b00, 7'h01, 6'd1,  6'd1,  6'd1,  6'd1,  7'h40,   16'h0000, 26'h0,       1'b0, 32'h0);
      vecs[10] = mk(2'b01, 7'h01, 6'd1,  6'd32, 6'd0,  6'd0,  7'd0,    16'h1234, 26'h0,       1'b0, 32'h0);
      vecs[11] = mk(2'b00, 7'h01, 6'd1,  6'd1,  6'd1,  6'd32, 7'd1,    16'h0000, 26'h0,       1'b0, 32'h0);
      vecs[12] = mk(2'b00, 7'h01, 6'd1,  6'd1,  6'd32, 6'd1,  7'd1,    16'h0000, 26'h0,       1'b0, 32'h0);

      // Reset
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      clear_fields();
      step();
      step();
      rst = 1'b0;
      check("rst_count",     32'(count),         32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_err_pulse", 32'(err_pulse),     32'd0);
      check("rst_err_cnt",   32'(err_cnt),       32'd0);
      check("rst_out_word",  bus.out_word,       32'd0);
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);

      // Table: one bundle in, then drain
      exp_err = 0;
      for (int i = 0; i < 13; i++) begin
         drive_vec(vecs[i]);
         step();
         bus.in_valid = 1'b0;
         if (vecs[i].legal) begin
            check($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("v%0d_word", i),      bus.out_word,       vecs[i].word);
            check($sformatf("v%0d_count", i),     32'(count),         32'd1);
            check($sformatf("v%0d_err_pulse", i), 32'(err_pulse),     32'd0);
         end else begin
            exp_err++;
            check($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'd0);
            check($sformatf("v%0d_count", i),     32'(count),         32'd0);
            check($sformatf("v%0d_err_pulse", i), 32'(err_pulse),     32'd1);
         end
         check($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'(exp_err));
         bus.out_ready = 1'b1;
         step();
         bus.out_ready = 1'b0;
         check($sformatf("v%0d_drained", i),    32'(count),     32'd0);
         check($sformatf("v%0d_pulse_end", i),  32'(err_pulse), 32'd0);
      end

      // I then J held, then released in order
      drive_vec(vecs[1]);
      step();
      drive_vec(vecs[2]);
      step();
      bus.in_valid = 1'b0;
      check("ij_count", 32'(count), 32'd2);
      bus.out_ready = 1'b1;
      check("ij_first", bus.out_word, 32'h8C280020);
      step();
      check("ij_second", bus.out_word, 32'h08ABCDEF);
      step();
      bus.out_ready = 1'b0;
      check("ij_empty", 32'(count), 32'd0);

      // Fill to 4, fifth held off until a pop
      for (int i = 0; i < 4; i++) begin
         drive_j(26'(32'h100 + i));
         step();
      end
      check("fill_count4", 32'(count), 32'd4);
      drive_j(26'h104);
      check("fill_in_ready0", 32'(bus.in_ready), 32'd0);
      step();
      step();
      check("fill_held", 32'(count), 32'd4);
      bus.out_ready = 1'b1;
      check("fill_ready_with_pop", 32'(bus.in_ready), 32'd0);
      check("fill_head0", bus.out_word, 32'h08000100);
      step();
      bus.out_ready = 1'b0;
      check("fill_after_pop", 32'(count), 32'd3);
      check("fill_in_ready1", 32'(bus.in_ready), 32'd1);
      step();
      bus.in_valid = 1'b0;
      check("fill_refill", 32'(count), 32'd4);
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("fill_order%0d", i), bus.out_word, 32'h08000100 + 32'(i));
         step();
      end
      bus.out_ready = 1'b0;
      check("fill_empty", 32'(count), 32'd0);
      check("fill_out_valid0", 32'(bus.out_valid), 32'd0);

      // Streaming at count 2
      drive_j(26'h200);
      step();
      drive_j(26'h201);
      step();
      check("stream_count_start", 32'(count), 32'd2);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         drive_j(26'(32'h202 + k));
         check($sformatf("stream_head%0d", k), bus.out_word, 32'h08000200 + 32'(k));
         step();
         check($sformatf("stream_count%0d", k), 32'(count), 32'd2);
      end
      bus.in_valid = 1'b0;
      check("stream_tail0", bus.out_word, 32'h0800020A);
      step();
      check("stream_tail1", bus.out_word, 32'h0800020B);
      step();
      bus.out_ready = 1'b0;
      check("stream_empty", 32'(count), 32'd0);

      // Illegal pair from a clean error count
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_fields();
      bus.fmt = 2'b11;
      bus.in_valid = 1'b1;
      step();
      check("ill1_pulse", 32'(err_pulse), 32'd1);
      check("ill1_cnt",   32'(err_cnt),   32'd1);
      bus.fmt = 2'b00;
      bus.rs  = 6'd32;
      step();
      bus.in_valid = 1'b0;
      check("ill2_pulse", 32'(err_pulse), 32'd1);
      check("ill2_cnt",   32'(err_cnt),   32'd2);
      check("ill2_count", 32'(count),     32'd0);
      step();
      check("ill_pulse_end", 32'(err_pulse), 32'd0);
      check("ill_cnt_hold",  32'(err_cnt),   32'd2);

      // Illegal accept alongside a pop
      drive_j(26'h300);
      step();
      check("illpop_pre", 32'(count), 32'd1);
      clear_fields();
      bus.fmt = 2'b11;
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      check("illpop_count", 32'(count),     32'd0);
      check("illpop_pulse", 32'(err_pulse), 32'd1);
      check("illpop_cnt",   32'(err_cnt),   32'd3);

      // Saturation
      bus.in_valid = 1'b1;
      repeat (256) step();
      bus.in_valid = 1'b0;
      check("sat_cnt", 32'(err_cnt), 32'd255);
      step();
      check("sat_hold",  32'(err_cnt),   32'd255);
      check("sat_pulse", 32'(err_pulse), 32'd0);
      check("sat_count", 32'(count),     32'd0);

      // Reset with three queued and an accept pending
      for (int i = 0; i < 3; i++) begin
         drive_j(26'(32'h400 + i));
         step();
      end
      check("rst3_pre", 32'(count), 32'd3);
      drive_j(26'h403);
      bus.out_ready = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      check("rst3_count",     32'(count),         32'd0);
      check("rst3_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst3_err_cnt",   32'(err_cnt),       32'd0);
      check("rst3_in_ready",  32'(bus.in_ready),  32'd1);
      check("rst3_out_word",  bus.out_word,       32'd0);
      drive_j(26'h500);
      step();
      bus.in_valid = 1'b0;
      check("post_rst_word", bus.out_word, 32'h08000500);
      check("post_rst_count", 32'(count), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 in_valid  input  1  field bundle present.
REQ-004 in_ready  output  1  encoder can accept a bundle this cycle.
REQ-005 fmt  input  2  format: 00 R-type, 01 I-type, 10 J-type, 11 illegal.
REQ-006 op  input  7  opcode field; only bits 5:0 encodable.
REQ-007 rs, rt, rd, shamt  input  6 each  register and shift fields; only bits 4:0 encodable.
REQ-008 func  input  7  function field; only bits 5:0 encodable.
REQ-009 offset  input  16  I-type immediate.
REQ-010 target  input  26  J-type target.
REQ-011 out_word  output  32  encoded instruction at FIFO head.
REQ-012 out_valid  output  1  out_word is valid.
REQ-013 out_ready  input  1  consumer takes out_word.
REQ-014 count  output  3  FIFO occupancy, 0..4.
REQ-015 err_pulse  output  1  one-cycle flag: the bundle accepted in the previous cycle was rejected.
REQ-016 err_cnt  output  8  saturating count of rejected bundles.

Function
REQ-017 Accept = in_valid && in_ready; pop = out_valid && out_ready.
REQ-018 in_ready = (count < 4); it is combinational from count only, with no full-FIFO bypass.
REQ-019 R-type word = {op[5:0], rs[4:0], rt[4:0], rd[4:0], shamt[4:0], func[5:0]}.
REQ-020 I-type word = {op[5:0], rs[4:0], rt[4:0], offset[15:0]}; rd, shamt and func are ignored.
REQ-021 J-type word = {op[5:0], target[25:0]}; all other fields are ignored.
REQ-022 A bundle is illegal if any of these holds: fmt==11; op[6]==1; for R-type, rs[5], rt[5], rd[5], shamt[5] or func[6] is 1; for I-type, rs[5] or rt[5] is 1.
REQ-023 A legal accepted bundle is written to the FIFO tail on the accepting edge; out_valid rises the next cycle when the FIFO was empty (latency 1 cycle).
REQ-024 An illegal accepted bundle is consumed but not enqueued; err_pulse = 1 for exactly the following cycle; err_cnt increments and saturates at 255.
REQ-025 The FIFO has 4 entries, is ordered first-in first-out, and uses 2-bit read and write pointers that wrap 3->0.
REQ-026 out_valid = (count != 0); out_word is the head entry and is held stable while out_valid && !out_ready.
REQ-027 Legal accept and pop in the same cycle: count is unchanged and both pointers advance; this applies at any count 1..3.
REQ-028 At count==4: in_ready = 0, even if out_ready = 1 in that cycle.
REQ-029 Pop at count==0 is impossible because out_valid = 0; out_ready is don't-care.
REQ-030 Illegal accept together with a pop: count decrements by 1.
REQ-031 There is no combinational path from in_* to out_*.

Reset
REQ-032 While rst = 1 at a clock edge: count = 0, pointers = 0, out_valid = 0, err_pulse = 0, err_cnt = 0, out_word = 0.
REQ-033 Reset overrides a simultaneous accept or pop; in-flight entries are discarded; in_ready = 1 in the first cycle after reset.

Verification
REQ-034 R-type: op=0, rs=31, rt=7, rd=9, shamt=0, func=3, out_ready=1 -> next cycle out_word=0x03E74803, out_valid=1.
REQ-035 I-type op=0x23, rs=1, rt=8, offset=0x0020 followed by J-type op=2, target=0x0ABCDEF, out_ready=0 -> count=2; then out_ready=1 -> 0x8C280020 then 0x08ABCDEF, in order.
REQ-036 Fill: 5 back-to-back legal bundles with out_ready=0 -> count=4, in_ready=0 during the 5th; 5th is not accepted until one pop; no entry is lost or duplicated.
REQ-037 Illegal bundle: fmt=11, then rs=32 with R-type -> two err_pulse cycles, err_cnt=2, count unchanged; 256 illegal bundles -> err_cnt=255.
REQ-038 Simultaneous legal accept and pop at count=2 for 10 cycles -> count stays 2; output order matches input order.
REQ-039 rst asserted with count=3 and an accept pending -> next cycle count=0, out_valid=0, err_cnt=0, in_ready=1.
